// File: rtl/life_pkg.sv
// Shared Game-of-Life grid geometry, bank type and scheduler state encoding.
package life_pkg;

  localparam int GRID_SIZE  = 20;
  localparam int CELL_IDX_W = 5;
  localparam int CELL_CNT   = GRID_SIZE * GRID_SIZE;

  // Bit r*GRID_SIZE+c of the flattened vector is cell (r,c).
  typedef logic [GRID_SIZE-1:0][GRID_SIZE-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    SWAP    = 2'd2
  } sched_state_t;

endpackage

// File: rtl/life_cell_rule.sv
// Conway rule for one cell: born on exactly 3 neighbours, survives on 2 or 3.
module life_cell_rule (
  input  logic       alive,
  input  logic [7:0] nbrs,
  output logic       next_alive
);

  logic [3:0] n_count;

  // Neighbour population count, 0..8
  always_comb begin
    n_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n_count = n_count + {3'd0, nbrs[i]};
    end
  end

  assign next_alive = (n_count == 4'd3) | (alive & (n_count == 4'd2));

endmodule

// File: rtl/life_gen_scheduler.sv
// Double-buffered Life grid, one generation per vblank trigger, one cell per clock.
// LIFE_WRAP_EDGES_EN selects a toroidal grid; otherwise off-grid neighbours are dead.
module life_gen_scheduler
  import life_pkg::*;
#(
  parameter int FRAMES_PER_GEN = 30
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_vblank_n,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_load,
  input  logic [CELL_CNT-1:0]   i_seed,
  input  logic [CELL_IDX_W-1:0] i_rd_row,
  input  logic [CELL_IDX_W-1:0] i_rd_col,
  output logic                  o_rd_cell,
  output logic                  o_busy,
  output logic                  o_swap,
  output logic [15:0]           o_gen_count
);

  localparam logic [CELL_IDX_W-1:0] LAST_IDX  = CELL_IDX_W'(GRID_SIZE - 1);
  localparam logic [15:0]           FRAME_TOP = 16'(FRAMES_PER_GEN - 1);

  sched_state_t          state, state_nx;
  grid_t                 bank0, bank1, front;
  logic                  front_sel, vb_q, step_pend;
  logic [15:0]           frame_cnt, gen_count;
  logic [CELL_IDX_W-1:0] row, col;
  logic [CELL_IDX_W-1:0] row_up, row_dn, col_lf, col_rt;
  logic                  up_ok, dn_ok, lf_ok, rt_ok;
  logic                  vb_fall, frame_hit, start, last_cell;
  logic [7:0]            nbrs;
  logic                  next_alive;

  assign front     = front_sel ? bank1 : bank0;
  assign vb_fall   = vb_q & ~i_vblank_n;
  assign frame_hit = i_run & (frame_cnt == FRAME_TOP);
  assign start     = (state == IDLE) & vb_fall & ~i_load & (frame_hit | step_pend);
  assign last_cell = (row == LAST_IDX) & (col == LAST_IDX);

  assign row_up = (row == '0)       ? LAST_IDX : row - 5'd1;
  assign row_dn = (row == LAST_IDX) ? 5'd0     : row + 5'd1;
  assign col_lf = (col == '0)       ? LAST_IDX : col - 5'd1;
  assign col_rt = (col == LAST_IDX) ? 5'd0     : col + 5'd1;

`ifdef LIFE_WRAP_EDGES_EN
  assign up_ok = 1'b1;
  assign dn_ok = 1'b1;
  assign lf_ok = 1'b1;
  assign rt_ok = 1'b1;
`else
  // Wrapped indices are still computed; the masks kill them at the border.
  assign up_ok = (row != '0);
  assign dn_ok = (row != LAST_IDX);
  assign lf_ok = (col != '0);
  assign rt_ok = (col != LAST_IDX);
`endif

  assign nbrs = {front[row_up][col_lf] & up_ok & lf_ok,
                 front[row_up][col]    & up_ok,
                 front[row_up][col_rt] & up_ok & rt_ok,
                 front[row][col_lf]    & lf_ok,
                 front[row][col_rt]    & rt_ok,
                 front[row_dn][col_lf] & dn_ok & lf_ok,
                 front[row_dn][col]    & dn_ok,
                 front[row_dn][col_rt] & dn_ok & rt_ok};

  life_cell_rule u_rule (
    .alive      (front[row][col]),
    .nbrs       (nbrs),
    .next_alive (next_alive)
  );

  // Scheduler state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; a load always returns to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = COMPUTE;
        else       state_nx = IDLE;
      end
      COMPUTE: begin
        if (i_load)         state_nx = IDLE;
        else if (last_cell) state_nx = SWAP;
        else                state_nx = COMPUTE;
      end
      SWAP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grid banks, scan counters, frame pacing and generation count
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bank0     <= '0;
      bank1     <= '0;
      front_sel <= 1'b0;
      vb_q      <= 1'b0;
      step_pend <= 1'b0;
      frame_cnt <= 16'd0;
      gen_count <= 16'd0;
      row       <= '0;
      col       <= '0;
    end else begin
      vb_q      <= i_vblank_n;
      step_pend <= i_step | (step_pend & ~start);
      if (i_load) begin
        if (front_sel) bank1 <= grid_t'(i_seed);
        else           bank0 <= grid_t'(i_seed);
        gen_count <= 16'd0;
        frame_cnt <= 16'd0;
        row       <= '0;
        col       <= '0;
      end else begin
        case (state)
          IDLE: begin
            row <= '0;
            col <= '0;
            if (vb_fall && i_run) begin
              frame_cnt <= frame_hit ? 16'd0 : frame_cnt + 16'd1;
            end
          end
          COMPUTE: begin
            if (front_sel) bank0[row][col] <= next_alive;
            else           bank1[row][col] <= next_alive;
            if (col == LAST_IDX) begin
              col <= '0;
              row <= row + 5'd1;
            end else begin
              col <= col + 5'd1;
            end
          end
          SWAP: begin
            front_sel <= ~front_sel;
            gen_count <= gen_count + 16'd1;
            row       <= '0;
            col       <= '0;
          end
          default: begin
            row <= '0;
            col <= '0;
          end
        endcase
      end
    end
  end

  assign o_busy      = (state == COMPUTE);
  assign o_swap      = (state == SWAP);
  assign o_gen_count = gen_count;
  assign o_rd_cell   = ((i_rd_row <= LAST_IDX) && (i_rd_col <= LAST_IDX)) ?
                       front[i_rd_row][i_rd_col] : 1'b0;

endmodule
